// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencing controller:
// op_code values, FSM state encoding and default datapath width.
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_MUL,
    ST_WAIT_DIV,
    ST_COMMIT
  } state_e;

endpackage

// File: rtl/muldiv_watchdog.sv
// Loadable saturating down-counter; flags expiry while enabled and at zero.
// Instantiated by muldiv_ctrl only when MULDIV_TIMEOUT_EN is defined.
module muldiv_watchdog #(
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;

  // Loaded with N-1 so that expiry is seen on the Nth enabled cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(TIMEOUT_CYCLES - 1);
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_expired = i_en && (r_cnt == '0);

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the multicycle HI/LO units: launch, wait for done, commit.
// Optional watchdog on the wait states is enabled by defining MULDIV_TIMEOUT_EN.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH          = MULDIV_WIDTH,
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             abort,
  output logic             mul_start,
  output logic             div_start,
  output logic [WIDTH-1:0] unit_a,
  output logic [WIDTH-1:0] unit_b,
  output logic             unit_signed,
  input  logic             mul_done,
  input  logic             div_done,
  input  logic [WIDTH-1:0] unit_hi,
  input  logic [WIDTH-1:0] unit_lo,
  input  logic             rd_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             div_zero,
  output logic             op_err
);

  state_e           r_state;
  logic             r_kind;
  logic [WIDTH-1:0] r_unit_a, r_unit_b, r_hi, r_lo;
  logic [WIDTH-1:0] r_stage_hi, r_stage_lo;
  logic             r_unit_signed, r_div_zero, r_op_err;

  logic w_accept, w_is_div, w_waiting, w_done, w_wd_expired;

  // abort in IDLE drops a same-cycle request, including MTHI/MTLO.
  assign w_accept  = op_valid && (r_state == ST_IDLE) && !abort;
  assign w_is_div  = (op_code == OP_DIV) || (op_code == OP_DIVU);
  assign w_waiting = (r_state == ST_WAIT_MUL) || (r_state == ST_WAIT_DIV);
  assign w_done    = ((r_state == ST_WAIT_MUL) && mul_done) ||
                     ((r_state == ST_WAIT_DIV) && div_done);

`ifdef MULDIV_TIMEOUT_EN
  muldiv_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .i_load    (r_state == ST_LAUNCH),
    .i_en      (w_waiting),
    .o_expired (w_wd_expired)
  );
`else
  assign w_wd_expired = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk) begin
    r_div_zero <= 1'b0;
    r_op_err   <= 1'b0;
    if (reset) begin
      r_state       <= ST_IDLE;
      r_kind        <= 1'b0;
      r_unit_a      <= '0;
      r_unit_b      <= '0;
      r_unit_signed <= 1'b0;
      r_hi          <= '0;
      r_lo          <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            case (op_code)
              OP_MTHI: r_hi <= op_a;
              OP_MTLO: r_lo <= op_a;
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                if (w_is_div && (op_b == '0)) begin
                  r_div_zero <= 1'b1;
                end else begin
                  r_unit_a      <= op_a;
                  r_unit_b      <= op_b;
                  r_unit_signed <= ~op_code[0];
                  r_kind        <= w_is_div;
                  r_state       <= ST_LAUNCH;
                end
              end
              default: r_op_err <= 1'b1;
            endcase
          end
        end
        ST_LAUNCH: begin
          if (abort)       r_state <= ST_IDLE;
          else if (r_kind) r_state <= ST_WAIT_DIV;
          else             r_state <= ST_WAIT_MUL;
        end
        ST_WAIT_MUL, ST_WAIT_DIV: begin
          if (abort) begin
            r_state <= ST_IDLE;
          end else if (w_done) begin
            r_state <= ST_COMMIT;
          end else if (w_wd_expired) begin
            r_state  <= ST_IDLE;
            r_op_err <= 1'b1;
          end
        end
        ST_COMMIT: begin
          if (!abort) begin
            r_hi <= r_stage_hi;
            r_lo <= r_stage_lo;
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Result staging is pure data; it is only consumed after a capture.
  always_ff @(posedge clk) begin
    if (w_done) begin
      r_stage_hi <= unit_hi;
      r_stage_lo <= unit_lo;
    end
  end

  assign mul_start   = (r_state == ST_LAUNCH) && !r_kind && !abort && !reset;
  assign div_start   = (r_state == ST_LAUNCH) &&  r_kind && !abort && !reset;
  assign op_ready    = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign stall       = rd_req && busy;
  assign unit_a      = r_unit_a;
  assign unit_b      = r_unit_b;
  assign unit_signed = r_unit_signed;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_zero    = r_div_zero;
  assign op_err      = r_op_err;

endmodule
